// File: rtl/acc_seq_pkg.sv
// Shared types and constants for the acc_sequencer accumulator machine.
package acc_seq_pkg;

    localparam int INSTR_W = 12;
    localparam int DATA_W  = 8;

    // Opcodes 0x0-0x7 and 0x9-0xC go to the ALU; 0x8 and 0xD-0xF are handled locally.
    typedef enum logic [3:0] {
        OP_PASSB = 4'h0,
        OP_PASSA = 4'h1,
        OP_ADD   = 4'h2,
        OP_SUB   = 4'h3,
        OP_AND   = 4'h4,
        OP_OR    = 4'h5,
        OP_XOR   = 4'h6,
        OP_NOTA  = 4'h7,
        OP_NOP   = 4'h8,
        OP_CLR   = 4'h9,
        OP_INC   = 4'hA,
        OP_DEC   = 4'hB,
        OP_CPL   = 4'hC,
        OP_JMP   = 4'hD,
        OP_JC    = 4'hE,
        OP_HALT  = 4'hF
    } opcode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LOAD  = 2'd2,
        EXEC  = 2'd3
    } state_e;

    // True for opcodes whose result is written back from the ALU.
    function automatic logic is_alu_op(input opcode_e op);
        return (op <= OP_CPL) && (op != OP_NOP);
    endfunction

endpackage

// File: rtl/acc_sequencer_acc_reg.sv
// Accumulator and carry register with write enable and synchronous active-low clear.
module acc_reg
    import acc_seq_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic         i_clk,
    input  logic         i_clr_n,
    input  logic         i_we,
    input  logic [W-1:0] i_acc,
    input  logic         i_carry,
    output logic [W-1:0] o_acc,
    output logic         o_carry
);

    logic [W-1:0] r_acc;
    logic         r_carry;

    // Clear has priority over a pending write so a reset mid-instruction drops the writeback.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block ordering.
        if (!i_clr_n) begin
            r_acc   <= '0;
            r_carry <= 1'b0;
        end else if (i_we) begin
            r_acc   <= i_acc;
            r_carry <= i_carry;
        end
    end

    assign o_acc   = r_acc;
    assign o_carry = r_carry;

endmodule

// File: rtl/acc_sequencer.sv
// acc_sequencer: fetch/load/exec control stage driving an external 8-bit ALU.
// Optional instruction watchdog enabled by defining ACC_SEQUENCER_WDOG_EN.
module acc_sequencer
    import acc_seq_pkg::*;
#(
    parameter int PC_W       = 8,
    parameter int WDOG_LIMIT = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic [PC_W-1:0]    prog_addr,
    input  logic [INSTR_W-1:0] prog_data,
    output logic [3:0]         alu_inst,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    input  logic [DATA_W:0]    alu_ans,
    output logic [DATA_W-1:0]  acc,
    output logic               carry_flag,
    output logic               busy,
    output logic               done,
    output logic               timeout
);

    state_e              r_state;
    logic [PC_W-1:0]     r_pc;
    logic [INSTR_W-1:0]  r_ir;
    opcode_e             r_alu_inst;
    logic                r_busy;
    logic                r_done;

    opcode_e             w_op;
    logic [DATA_W-1:0]   w_imm;
    logic [PC_W-1:0]     w_target;
    logic [PC_W-1:0]     w_pc_inc;
    logic                w_abort;
    logic                w_wb;

    if (PC_W < 1 || WDOG_LIMIT < 1) begin : g_bad_params
        $error("acc_sequencer: PC_W and WDOG_LIMIT must be at least 1");
    end

    assign w_op     = opcode_e'(r_ir[INSTR_W-1:DATA_W]);
    assign w_imm    = r_ir[DATA_W-1:0];
    assign w_pc_inc = r_pc + PC_W'(1);

    // Jump target is the immediate, zero-extended or truncated to the pc width.
    if (PC_W > DATA_W) begin : g_tgt_wide
        assign w_target = {{(PC_W-DATA_W){1'b0}}, w_imm};
    end else begin : g_tgt_narrow
        assign w_target = w_imm[PC_W-1:0];
    end

`ifdef ACC_SEQUENCER_WDOG_EN
    localparam int CNT_W = $clog2(WDOG_LIMIT + 1);

    logic [CNT_W-1:0] r_icnt;
    logic [CNT_W-1:0] w_icnt_inc;
    logic             r_timeout;

    assign w_icnt_inc = r_icnt + CNT_W'(1);
    assign w_abort    = (r_state == EXEC) && (w_icnt_inc == CNT_W'(WDOG_LIMIT)) &&
                        (w_op != OP_HALT);

    // Count executed instructions per run; the sticky timeout clears on the next start.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_icnt    <= '0;
            r_timeout <= 1'b0;
        end else if (r_state == IDLE && start) begin
            r_icnt    <= '0;
            r_timeout <= 1'b0;
        end else if (r_state == EXEC) begin
            r_icnt <= w_icnt_inc;
            if (w_abort) r_timeout <= 1'b1;
        end
    end

    assign timeout = r_timeout;
`else
    assign w_abort = 1'b0;
    assign timeout = 1'b0;
`endif

    // ALU results are written back at the end of EXEC unless the watchdog aborts.
    assign w_wb = (r_state == EXEC) && is_alu_op(w_op) && !w_abort;

    acc_reg #(.W(DATA_W)) u_acc_reg (
        .i_clk   (clk),
        .i_clr_n (reset),
        .i_we    (w_wb),
        .i_acc   (alu_ans[DATA_W-1:0]),
        .i_carry (alu_ans[DATA_W]),
        .o_acc   (acc),
        .o_carry (carry_flag)
    );

    // Sequencer FSM: IDLE -> FETCH -> LOAD -> EXEC, with registered control outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_pc       <= '0;
            r_ir       <= '0;
            r_alu_inst <= OP_NOP;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_pc    <= '0;
                        r_busy  <= 1'b1;
                        r_state <= FETCH;
                    end
                end
                FETCH: begin
                    r_state <= LOAD;
                end
                LOAD: begin
                    r_ir       <= prog_data;
                    r_alu_inst <= is_alu_op(opcode_e'(prog_data[INSTR_W-1:DATA_W])) ?
                                  opcode_e'(prog_data[INSTR_W-1:DATA_W]) : OP_NOP;
                    r_state    <= EXEC;
                end
                EXEC: begin
                    r_alu_inst <= OP_NOP;
                    if (w_abort || w_op == OP_HALT) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        case (w_op)
                            OP_JMP:  r_pc <= w_target;
                            OP_JC:   r_pc <= carry_flag ? w_target : w_pc_inc;
                            default: r_pc <= w_pc_inc;
                        endcase
                        r_state <= FETCH;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign prog_addr = r_pc;
    assign alu_inst  = r_alu_inst;
    assign alu_a     = acc;
    assign alu_b     = w_imm;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_acc_sequencer.sv
// Self-checking bench for acc_sequencer: directed programs, randomized programs
// against an instruction-level reference model, and a PC_W=2 wrap/watchdog instance.
module tb_acc_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  prog_addr;
    logic [11:0] prog_data = '0;
    logic [3:0]  alu_inst;
    logic [7:0]  alu_a, alu_b, acc;
    logic [8:0]  alu_ans;
    logic        carry_flag, busy, done, timeout;

    logic        start2 = 1'b0;
    logic [1:0]  prog_addr2;
    logic [11:0] prog_data2 = '0;
    logic [3:0]  alu_inst2;
    logic [7:0]  alu_a2, alu_b2, acc2;
    logic [8:0]  alu_ans2;
    logic        carry_flag2, busy2, done2, timeout2;

    logic [11:0] rom  [0:255];
    logic [11:0] rom2 [0:3];

    int checks = 0;
    int failures = 0;

    logic [7:0] obs_acc [0:63];
    logic       obs_cy  [0:63];
    logic [3:0] obs_inst[0:63];
    logic [7:0] obs_a   [0:63];
    logic [7:0] obs_b   [0:63];
    logic [7:0] obs_addr[0:63];
    logic       obs_busy[0:63];

    // Reference model state: architectural accumulator and carry.
    logic [7:0] m_acc = '0;
    logic       m_carry = 1'b0;

    always #5 clk = ~clk;

    acc_sequencer #(.PC_W(8), .WDOG_LIMIT(255)) dut (
        .clk(clk), .reset(reset), .start(start), .prog_addr(prog_addr),
        .prog_data(prog_data), .alu_inst(alu_inst), .alu_a(alu_a), .alu_b(alu_b),
        .alu_ans(alu_ans), .acc(acc), .carry_flag(carry_flag), .busy(busy),
        .done(done), .timeout(timeout)
    );

    acc_sequencer #(.PC_W(2), .WDOG_LIMIT(6)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .prog_addr(prog_addr2),
        .prog_data(prog_data2), .alu_inst(alu_inst2), .alu_a(alu_a2), .alu_b(alu_b2),
        .alu_ans(alu_ans2), .acc(acc2), .carry_flag(carry_flag2), .busy(busy2),
        .done(done2), .timeout(timeout2)
    );

    // Behavioural ALU: 9-bit result, bit 8 is carry/borrow.
    function automatic logic [8:0] alu_fn(input logic [3:0] op, input logic [7:0] a,
                                          input logic [7:0] b);
        case (op)
            4'h0:    return {1'b0, b};
            4'h1:    return {1'b0, a};
            4'h2:    return {1'b0, a} + {1'b0, b};
            4'h3:    return {1'b0, b} - {1'b0, a};
            4'h4:    return {1'b0, a & b};
            4'h5:    return {1'b0, a | b};
            4'h6:    return {1'b0, a ^ b};
            4'h7:    return {1'b0, ~a};
            4'h9:    return 9'h000;
            4'hA:    return {1'b0, a} + 9'd1;
            4'hB:    return {1'b0, a} - 9'd1;
            4'hC:    return {1'b0, ~b};
            default: return {1'b0, a};
        endcase
    endfunction

    always_comb alu_ans  = alu_fn(alu_inst, alu_a, alu_b);
    always_comb alu_ans2 = alu_fn(alu_inst2, alu_a2, alu_b2);

    // Synchronous program ROMs: data appears one cycle after the address.
    always @(posedge clk) begin
        prog_data  <= rom[prog_addr];
        prog_data2 <= rom2[prog_addr2];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 12'h000;
    endtask

    // Instruction-level interpreter; returns the number of instructions executed.
    task automatic model_run(output int n);
        int  pc = 0;
        bit  halted = 0;
        logic [11:0] w;
        n = 0;
        while (!halted && n < 1000) begin
            w = rom[pc];
            n++;
            case (w[11:8])
                4'hF: halted = 1;
                4'hD: pc = int'(w[7:0]);
                4'hE: pc = m_carry ? int'(w[7:0]) : pc + 1;
                4'h8: pc = pc + 1;
                default: begin
                    {m_carry, m_acc} = alu_fn(w[11:8], m_acc, w[7:0]);
                    pc = pc + 1;
                end
            endcase
            pc = pc % 256;
        end
    endtask

    // Start the main DUT from a negedge and sample each following negedge until done.
    task automatic run_main(input int pulse_at, output int k_done);
        int k = 0;
        bit seen = 0;
        start = 1'b1;
        while (!seen && k < 200) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            start = (k == pulse_at);
            if (k < 64) begin
                obs_acc[k]  = acc;
                obs_cy[k]   = carry_flag;
                obs_inst[k] = alu_inst;
                obs_a[k]    = alu_a;
                obs_b[k]    = alu_b;
                obs_addr[k] = prog_addr;
                obs_busy[k] = busy;
            end
            if (done) seen = 1;
        end
        start = 1'b0;
        k_done = seen ? k : -1;
        if (seen) begin
            @(posedge clk);
            @(negedge clk);
            check("done_one_cycle", done, 0);
            check("idle_after_halt", busy, 0);
        end
    endtask

    initial begin
        int kd;
        int n;
        clear_rom();
        for (int i = 0; i < 4; i++) rom2[i] = 12'h000;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_timeout", timeout, 0);
        check("rst_alu_inst", alu_inst, 4'h8);
        check("rst_acc", acc, 0);
        check("rst_carry", carry_flag, 0);
        check("rst_prog_addr", prog_addr, 0);
        reset = 1'b1;
        @(negedge clk);

        // Test 1: 5 + 3 = 8; start held on the halt edge must be ignored.
        clear_rom();
        rom[0] = 12'h005; rom[1] = 12'h203; rom[2] = 12'hF00;
        run_main(9, kd);
        check("t1_done_cycle", kd, 10);
        check("t1_acc", acc, 8'h08);
        check("t1_carry", carry_flag, 0);
        check("t1_busy_first", obs_busy[1], 1);
        check("t1_fetch_inst", obs_inst[1], 4'h8);
        check("t1_exec0_inst", obs_inst[3], 4'h0);
        check("t1_exec0_a", obs_a[3], 8'h00);
        check("t1_exec0_b", obs_b[3], 8'h05);
        check("t1_exec1_inst", obs_inst[6], 4'h2);
        check("t1_exec1_a", obs_a[6], 8'h05);
        check("t1_exec1_b", obs_b[6], 8'h03);
        check("t1_halt_inst", obs_inst[9], 4'h8);
        m_acc = 8'h08; m_carry = 1'b0;

        // Test 2: add overflow sets carry, JC taken, clear, halt.
        clear_rom();
        rom[0] = 12'h0FF; rom[1] = 12'h201; rom[2] = 12'hE05; rom[3] = 12'hF00;
        rom[4] = 12'hF00; rom[5] = 12'h977; rom[6] = 12'hF00;
        run_main(-1, kd);
        check("t2_done_cycle", kd, 16);
        check("t2_add_acc", obs_acc[7], 8'h00);
        check("t2_add_carry", obs_cy[7], 1);
        check("t2_jc_target", obs_addr[10], 8'h05);
        check("t2_acc", acc, 8'h00);
        check("t2_carry", carry_flag, 0);
        check("t2_halt_addr", prog_addr, 8'h06);

        // Test 3: borrow on 3-5, NOP preserves; start pulse while busy is ignored.
        clear_rom();
        rom[0] = 12'h005; rom[1] = 12'h303; rom[2] = 12'h812; rom[3] = 12'hF00;
        run_main(4, kd);
        check("t3_done_cycle", kd, 13);
        check("t3_busy_start_pc", obs_addr[5], 8'h01);
        check("t3_sub_acc", obs_acc[7], 8'hFE);
        check("t3_sub_carry", obs_cy[7], 1);
        check("t3_acc", acc, 8'hFE);
        check("t3_carry", carry_flag, 1);

        // Test 4: reset during EXEC of 0x201 drops the writeback and never pulses done.
        clear_rom();
        rom[0] = 12'h005; rom[1] = 12'h201; rom[2] = 12'hF00;
        start = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
        end
        check("t4_acc_before", acc, 8'h05);
        check("t4_inst_before", alu_inst, 4'h2);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("t4_acc", acc, 0);
        check("t4_carry", carry_flag, 0);
        check("t4_busy", busy, 0);
        check("t4_done", done, 0);
        reset = 1'b1;
        @(negedge clk);
        check("t4_done_after", done, 0);
        m_acc = 8'h00; m_carry = 1'b0;

        // Randomized forward-only programs against the instruction-level model.
        for (int t = 0; t < 8; t++) begin
            int r;
            clear_rom();
            for (int i = 0; i < 15; i++) begin
                r = int'($urandom_range(0, 15));
                if (r == 13 || r == 14)
                    rom[i] = {4'(r), 8'($urandom_range(i + 1, 15))};
                else
                    rom[i] = {4'(r), 8'($urandom_range(0, 255))};
            end
            rom[15] = 12'hF00;
            model_run(n);
            run_main(-1, kd);
            check($sformatf("rnd%0d_done_cycle", t), kd, 3 * n + 1);
            check($sformatf("rnd%0d_acc", t), acc, m_acc);
            check($sformatf("rnd%0d_carry", t), carry_flag, m_carry);
            check($sformatf("rnd%0d_timeout", t), timeout, 0);
        end

        // PC_W=2 instance: pc wraps 3->0; watchdog aborts when enabled.
        rom2[0] = 12'h0AA; rom2[1] = 12'h800; rom2[2] = 12'h800; rom2[3] = 12'h800;
        begin
            int k = 0;
            int k_done2 = -1;
            logic [1:0] addr_at [0:63];
            start2 = 1'b1;
            while (k < 40 && k_done2 < 0) begin
                @(posedge clk);
                k++;
                @(negedge clk);
                start2 = 1'b0;
                addr_at[k] = prog_addr2;
                if (done2) k_done2 = k;
            end
            check("wrap_addr_3", (k >= 13) ? addr_at[12] : 2'bxx, 2'd3);
            check("wrap_addr_0", (k >= 13) ? addr_at[13] : 2'bxx, 2'd0);
            check("wrap_acc", acc2, 8'hAA);
`ifdef ACC_SEQUENCER_WDOG_EN
            check("wdog_done_cycle", k_done2, 19);
            check("wdog_timeout", timeout2, 1);
            check("wdog_busy", busy2, 0);
`else
            check("nowdog_no_done", k_done2, -1);
            check("nowdog_timeout", timeout2, 0);
            check("nowdog_busy", busy2, 1);
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time bound");
        $fatal(1, "time bound exceeded");
    end

endmodule
